// File: rtl/f_pc_ctrl_pkg.sv
// Shared constants for the fetch-stage PC controller: D-stage next-PC opcodes
// and the fetch FSM state encoding.
package f_pc_ctrl_pkg;

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_B   = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_RS  = 3'd3;

    typedef enum logic [0:0] {
        PCS_FETCH = 1'b0,
        PCS_HOLD  = 1'b1
    } pcs_t;

endpackage

// File: rtl/f_pc_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface f_pc_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/f_pc_ctrl_d_npc_target.sv
// Combinational D-stage redirect target: branch / j / jr target and whether
// the instruction in D actually redirects the fetch stream.
module d_npc_target
    import f_pc_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [2:0]        npc_op,
    input  logic              b_jump,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [ADDR_W-1:0] pc_d,
    output logic              redir,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] br_off;

    assign br_off = {{(ADDR_W-18){imm26[15]}}, imm26[15:0], 2'b00};

    always_comb begin
        redir  = 1'b0;
        target = pc_d + ADDR_W'(4) + br_off;
        case (npc_op)
            NPC_B: begin
                redir  = b_jump;
                target = pc_d + ADDR_W'(4) + br_off;
            end
            NPC_J: begin
                redir  = 1'b1;
                target = {pc_d[ADDR_W-1:28], imm26, 2'b00};
            end
            NPC_RS: begin
                redir  = 1'b1;
                target = rs_val;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/f_pc_ctrl.sv
// Fetch-stage PC controller: PC register, imem handshake, one-deep redirect
// buffer. Optional fetch address check built when NPC_ALIGN_CHECK_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   PCS_FETCH | request outstanding at pc_f; ack loads instr_f and advances
//   PCS_HOLD  | D stalled after a fetch completed; no request, outputs frozen
module f_pc_ctrl
    import f_pc_ctrl_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(32'h0000_4180),
    parameter logic [ADDR_W-1:0] IMEM_LO  = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0] IMEM_HI  = ADDR_W'(32'h0000_6FFC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        npc_op,
    input  logic              b_jump,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    f_pc_ctrl_if.master       imem,
    output logic [ADDR_W-1:0] pc_f,
    output logic [31:0]       instr_f,
    output logic              valid_f,
    output logic              adel_f
);

    pcs_t              state, state_nxt;
    logic              live, pend_v, discard;
    logic [ADDR_W-1:0] pend_pc;
    logic              redir, redir_ok;
    logic [ADDR_W-1:0] target, next_pc;
    logic              fetch_en, fetch_ack, adel_set, trap;
    logic              adel_q, pc_bad;

    d_npc_target #(.ADDR_W(ADDR_W)) u_target (
        .npc_op (npc_op),
        .b_jump (b_jump),
        .imm26  (imm26),
        .rs_val (rs_val),
        .pc_d   (pc_d),
        .redir  (redir),
        .target (target)
    );

    // A live redirect this cycle is newer than anything already buffered.
    assign trap     = exc_req | eret;
    assign redir_ok = redir & ~stall;
    assign next_pc  = redir_ok ? target : (pend_v ? pend_pc : pc_f + ADDR_W'(4));

`ifdef NPC_ALIGN_CHECK_EN
    assign pc_bad = (pc_f[1:0] != 2'b00) || (pc_f < IMEM_LO) || (pc_f > IMEM_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        adel_q <= 1'b0;
        else if (trap)     adel_q <= 1'b0;
        else if (adel_set) adel_q <= 1'b1;
    end
`else
    logic range_unused;
    assign range_unused = (pc_f < IMEM_LO) | (pc_f > IMEM_HI);
    assign pc_bad       = 1'b0;
    assign adel_q       = 1'b0;
`endif

    assign adel_f         = adel_q;
    assign fetch_en       = (state == PCS_FETCH) & live & ~discard & ~adel_q;
    assign adel_set       = fetch_en & pc_bad;
    assign imem.imem_req  = fetch_en & ~pc_bad;
    assign imem.imem_addr = pc_f;
    assign fetch_ack      = imem.imem_req & imem.imem_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PCS_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (trap) begin
            state_nxt = PCS_FETCH;
        end else begin
            case (state)
                PCS_FETCH: if (fetch_ack && stall) state_nxt = PCS_HOLD;
                PCS_HOLD:  if (!stall)             state_nxt = PCS_FETCH;
                default:                           state_nxt = PCS_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live    <= 1'b0;
            pc_f    <= RESET_PC;
            instr_f <= '0;
            valid_f <= 1'b0;
            pend_v  <= 1'b0;
            pend_pc <= '0;
            discard <= 1'b0;
        end else begin
            live <= 1'b1;
            if (trap) begin
                pc_f    <= exc_req ? EXC_VEC : epc;
                valid_f <= 1'b0;
                pend_v  <= 1'b0;
                // An in-flight request still owes us one ack; swallow it.
                discard <= (discard & ~imem.imem_ack) | (imem.imem_req & ~imem.imem_ack);
            end else begin
                if (discard && imem.imem_ack) discard <= 1'b0;
                case (state)
                    PCS_FETCH: begin
                        if (adel_set) begin
                            valid_f <= 1'b1;
                            instr_f <= '0;
                        end else if (fetch_ack) begin
                            instr_f <= imem.imem_rdata;
                            valid_f <= 1'b1;
                            if (!stall) begin
                                pc_f   <= next_pc;
                                pend_v <= 1'b0;
                            end
                        end else if (redir_ok && !adel_q) begin
                            pend_pc <= target;
                            pend_v  <= 1'b1;
                        end
                    end
                    PCS_HOLD: begin
                        if (!stall) begin
                            pc_f    <= next_pc;
                            pend_v  <= 1'b0;
                            valid_f <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f_pc_ctrl.sv
// Directed scoreboard bench for f_pc_ctrl: stimulus queues expected fetch
// addresses, a negedge monitor checks every accepted imem request.
module tb_f_pc_ctrl;
    import f_pc_ctrl_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic [2:0]        npc_op;
    logic              b_jump;
    logic [25:0]       imm26;
    logic [ADDR_W-1:0] rs_val;
    logic [ADDR_W-1:0] pc_d;
    logic              exc_req;
    logic              eret;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc_f;
    logic [31:0]       instr_f;
    logic              valid_f;
    logic              adel_f;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    f_pc_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    f_pc_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .npc_op  (npc_op),
        .b_jump  (b_jump),
        .imm26   (imm26),
        .rs_val  (rs_val),
        .pc_d    (pc_d),
        .exc_req (exc_req),
        .eret    (eret),
        .epc     (epc),
        .imem    (bus),
        .pc_f    (pc_f),
        .instr_f (instr_f),
        .valid_f (valid_f),
        .adel_f  (adel_f)
    );

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fetch_unexpected actual=%h required=none", bus.imem_addr);
            end else begin
                chk("fetch_addr", bus.imem_addr, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic ack, input logic push, input logic [31:0] exp);
        bus.imem_ack = ack;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        stall   = 1'b0;
        npc_op  = NPC_SEQ;
        b_jump  = 1'b0;
        exc_req = 1'b0;
        eret    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; stall = 1'b0; npc_op = NPC_SEQ; b_jump = 1'b0; imm26 = '0;
        rs_val = '0; pc_d = '0; exc_req = 1'b0; eret = 1'b0; epc = '0;
        bus.imem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pc", pc_f, 32'h0000_3000);
        chk("rst_valid", valid_f, 1'b0);
        chk("rst_instr", instr_f, 32'h0);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_adel", adel_f, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);

        // sequential fetch
        cyc(1'b1, 1'b1, 32'h3000);
        chk("seq_valid", valid_f, 1'b1);
        chk("seq_instr", instr_f, 32'hA5A5_3000);
        chk("seq_pc", pc_f, 32'h3004);

        // beq taken, delay slot 0x3004 completes first
        pc_d = 32'h3000; npc_op = NPC_B; b_jump = 1'b1; imm26 = 26'h0003;
        cyc(1'b1, 1'b1, 32'h3004);
        chk("beq_taken", pc_f, 32'h3010);
        cyc(1'b1, 1'b1, 32'h3010);
        pc_d = 32'h3010; npc_op = NPC_B; b_jump = 1'b0; imm26 = 26'h0010;
        cyc(1'b1, 1'b1, 32'h3014);
        chk("beq_not_taken", pc_f, 32'h3018);
        pc_d = 32'h3014; npc_op = NPC_B; b_jump = 1'b1; imm26 = 26'h3FF_FFFE;
        cyc(1'b1, 1'b1, 32'h3018);
        chk("beq_backward", pc_f, 32'h3010);

        // j accepted while ack is delayed three cycles
        pc_d = 32'h300C; npc_op = NPC_J; imm26 = 26'h0C04;
        cyc(1'b0, 1'b0, 32'h0);
        chk("j_pend_pc_held", pc_f, 32'h3010);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h3010);
        chk("j_after_ack", pc_f, 32'h3010);
        cyc(1'b1, 1'b1, 32'h3010);
        chk("pend_cleared", pc_f, 32'h3014);

        // two pending redirects, the later one wins
        npc_op = NPC_RS; rs_val = 32'h3100;
        cyc(1'b0, 1'b0, 32'h0);
        npc_op = NPC_RS; rs_val = 32'h3200;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h3014);
        chk("pend_last_wins", pc_f, 32'h3200);

        // stall across an ack -> HOLD
        stall = 1'b1;
        cyc(1'b1, 1'b1, 32'h3200);
        chk("hold_req", bus.imem_req, 1'b0);
        chk("hold_pc", pc_f, 32'h3200);
        chk("hold_instr", instr_f, 32'hA5A5_3200);
        stall = 1'b1; npc_op = NPC_J; imm26 = 26'h0C40;
        cyc(1'b0, 1'b0, 32'h0);
        chk("hold_instr_stable", instr_f, 32'hA5A5_3200);
        chk("hold_pc_stable", pc_f, 32'h3200);
        cyc(1'b0, 1'b0, 32'h0);
        chk("hold_release_pc", pc_f, 32'h3204);
        chk("hold_release_valid", valid_f, 1'b0);
        chk("hold_release_req", bus.imem_req, 1'b1);
        cyc(1'b1, 1'b1, 32'h3204);
        chk("refetch_valid", valid_f, 1'b1);

        // exception with request outstanding: late ack discarded
        cyc(1'b0, 1'b0, 32'h0);
        exc_req = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);
        chk("exc_pc", pc_f, 32'h4180);
        chk("exc_valid", valid_f, 1'b0);
        chk("exc_req_blocked", bus.imem_req, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("discard_valid", valid_f, 1'b0);
        chk("discard_instr", instr_f, 32'hA5A5_3204);
        chk("discard_req_back", bus.imem_req, 1'b1);
        cyc(1'b1, 1'b1, 32'h4180);
        chk("exc_fetch_pc", pc_f, 32'h4184);
        chk("exc_fetch_instr", instr_f, 32'hA5A5_4180);

        // eret coinciding with an ack: ack dropped, no discard needed
        eret = 1'b1; epc = 32'h3020;
        cyc(1'b1, 1'b1, 32'h4184);
        chk("eret_pc", pc_f, 32'h3020);
        chk("eret_valid", valid_f, 1'b0);
        chk("eret_instr_kept", instr_f, 32'hA5A5_4180);
        cyc(1'b1, 1'b1, 32'h3020);
        chk("eret_fetch_instr", instr_f, 32'hA5A5_3020);
        exc_req = 1'b1; eret = 1'b1; epc = 32'h3500;
        cyc(1'b1, 1'b1, 32'h3024);
        chk("exc_over_eret", pc_f, 32'h4180);
        cyc(1'b1, 1'b1, 32'h4180);

        // jr to a misaligned address
        npc_op = NPC_RS; rs_val = 32'h3002;
        cyc(1'b1, 1'b1, 32'h4184);
        chk("jr_pc", pc_f, 32'h3002);
`ifdef NPC_ALIGN_CHECK_EN
        cyc(1'b0, 1'b0, 32'h0);
        chk("adel_flag", adel_f, 1'b1);
        chk("adel_valid", valid_f, 1'b1);
        chk("adel_instr", instr_f, 32'h0);
        chk("adel_no_req", bus.imem_req, 1'b0);
        cyc(1'b0, 1'b0, 32'h0);
        chk("adel_hold", adel_f, 1'b1);
        chk("adel_hold_pc", pc_f, 32'h3002);
        exc_req = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);
        chk("adel_cleared", adel_f, 1'b0);
        chk("adel_exc_pc", pc_f, 32'h4180);
        cyc(1'b1, 1'b1, 32'h4180);
`else
        cyc(1'b1, 1'b1, 32'h3002);
        chk("noalign_adel", adel_f, 1'b0);
        chk("noalign_pc", pc_f, 32'h3006);
        exc_req = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h4180);
`endif
        chk("final_pc", pc_f, 32'h4184);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
